mac_stream_tx: RTL and testbench

MAC_STREAM_TX -- requirements
Module: mac_stream_tx

---
 rtl/mac_stream_tx_if.sv | 36 +++
 rtl/mac_stream_tx.sv | 153 +++++++++++++++
 tb/tb_mac_stream_tx.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_stream_tx_if.sv
// Sample-in / MAC-out stream bundle for mac_stream_tx.
// master: the transmitter; slave: upstream source plus MAC FIFOs.
interface mac_stream_tx_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  samp_valid_i;
    logic [DATA_WIDTH-1:0] samp_data_i;
    logic                  samp_ready_o;
    logic                  full_mul_i;
    logic [DATA_WIDTH-1:0] signal_fifo;
    logic                  signal_wr_o;
    logic [DATA_WIDTH-1:0] coeff_fifo;
    logic                  coeff_wr_o;

    modport master (
        input  samp_valid_i,
        input  samp_data_i,
        input  full_mul_i,
        output samp_ready_o,
        output signal_fifo,
        output signal_wr_o,
        output coeff_fifo,
        output coeff_wr_o
    );

    modport slave (
        output samp_valid_i,
        output samp_data_i,
        output full_mul_i,
        input  samp_ready_o,
        input  signal_fifo,
        input  signal_wr_o,
        input  coeff_fifo,
        input  coeff_wr_o
    );
endinterface

// File: rtl/mac_stream_tx.sv
// Streams FP32 samples then stored coefficients (highest first) to a MAC,
// each stream closed by a NaN sentinel; backpressured by full_mul_i.
// Ports: clk_i/rst_i (sync, active-high), cw_* coefficient store write,
// start_i/n_terms_i/n_samp_i job setup, busy_o/done_o status,
// stream: sample handshake in, signal/coeff words out (master modport).
module mac_stream_tx #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_LINES = 5,
    parameter logic [DATA_WIDTH-1:0] SENTINEL   = 32'h7F90_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cw_en_i,
    input  logic [ADDR_LINES-1:0] cw_addr_i,
    input  logic [DATA_WIDTH-1:0] cw_data_i,
    input  logic                  start_i,
    input  logic [ADDR_LINES-1:0] n_terms_i,
    input  logic [ADDR_LINES:0]   n_samp_i,
    output logic                  busy_o,
    output logic                  done_o,
    mac_stream_tx_if.master       stream
);
    typedef enum logic [2:0] {
        IDLE,
        SIG,
        SIG_END,
        COEF,
        COEF_END,
        DONE
    } state_t;

    localparam int DEPTH = 2 ** ADDR_LINES;

    state_t                state_q, state_d;
    logic [ADDR_LINES:0]   cnt_q, cnt_d;
    logic [ADDR_LINES:0]   nsamp_q, nsamp_d;
    logic [ADDR_LINES-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sig_data_q, sig_data_d;
    logic                  sig_wr_q, sig_wr_d;
    logic [DATA_WIDTH-1:0] coef_data_q, coef_data_d;
    logic                  coef_wr_q, coef_wr_d;

    logic [DATA_WIDTH-1:0] store_q [DEPTH];

    logic                  samp_ready;
    logic                  accept;
    logic [ADDR_LINES:0]   cnt_inc;

    assign samp_ready = (state_q == SIG) && !stream.full_mul_i;
    assign accept     = samp_ready && stream.samp_valid_i;
    assign cnt_inc    = cnt_q + 1'b1;

    // Store is not reset; writes only land while idle.
    always_ff @(posedge clk_i) begin
        if (cw_en_i && state_q == IDLE) begin
            store_q[cw_addr_i] <= cw_data_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nsamp_d     = nsamp_q;
        idx_d       = idx_q;
        sig_data_d  = sig_data_q;
        sig_wr_d    = 1'b0;
        coef_data_d = coef_data_q;
        coef_wr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    nsamp_d = n_samp_i;
                    idx_d   = n_terms_i;
                    cnt_d   = '0;
                    state_d = (n_samp_i == '0) ? SIG_END : SIG;
                end
            end
            SIG: begin
                if (accept) begin
                    sig_data_d = stream.samp_data_i;
                    sig_wr_d   = 1'b1;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == nsamp_q) begin
                        state_d = SIG_END;
                    end
                end
            end
            SIG_END: begin
                if (!stream.full_mul_i) begin
                    sig_data_d = SENTINEL;
                    sig_wr_d   = 1'b1;
                    state_d    = COEF;
                end
            end
            COEF: begin
                if (!stream.full_mul_i) begin
                    coef_data_d = store_q[idx_q];
                    coef_wr_d   = 1'b1;
                    // Stop at index 0 instead of wrapping.
                    if (idx_q == '0) begin
                        state_d = COEF_END;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            COEF_END: begin
                if (!stream.full_mul_i) begin
                    coef_data_d = SENTINEL;
                    coef_wr_d   = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nsamp_q     <= '0;
            idx_q       <= '0;
            sig_data_q  <= '0;
            sig_wr_q    <= 1'b0;
            coef_data_q <= '0;
            coef_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nsamp_q     <= nsamp_d;
            idx_q       <= idx_d;
            sig_data_q  <= sig_data_d;
            sig_wr_q    <= sig_wr_d;
            coef_data_q <= coef_data_d;
            coef_wr_q   <= coef_wr_d;
        end
    end

    assign stream.samp_ready_o = samp_ready;
    assign stream.signal_fifo  = sig_data_q;
    assign stream.signal_wr_o  = sig_wr_q;
    assign stream.coeff_fifo   = coef_data_q;
    assign stream.coeff_wr_o   = coef_wr_q;

    assign busy_o = (state_q != IDLE) && (state_q != DONE);
    assign done_o = (state_q == DONE);
endmodule

// File: tb/tb_mac_stream_tx.sv
// Testbench for mac_stream_tx: table of stream jobs with a word scoreboard,
// plus hand-written reset-mid-stream and busy-poke sequences.
module tb_mac_stream_tx;
    localparam int          DW   = 32;
    localparam int          AL   = 5;
    localparam logic [31:0] SENT = 32'h7F90_0000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cw_en_i;
    logic [AL-1:0] cw_addr_i;
    logic [DW-1:0] cw_data_i;
    logic          start_i;
    logic [AL-1:0] n_terms_i;
    logic [AL:0]   n_samp_i;
    logic          busy_o;
    logic          done_o;

    mac_stream_tx_if #(.DATA_WIDTH(DW)) bus ();

    mac_stream_tx #(
        .DATA_WIDTH(DW),
        .ADDR_LINES(AL),
        .SENTINEL  (SENT)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cw_en_i  (cw_en_i),
        .cw_addr_i(cw_addr_i),
        .cw_data_i(cw_data_i),
        .start_i  (start_i),
        .n_terms_i(n_terms_i),
        .n_samp_i (n_samp_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .stream   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int nt;
        int ns;
        int vmode;
        int fmode;
        int stall_idx;
        int poke;
        int exp_sig;
        int exp_coef;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] model [32];
    logic [31:0] samp [40];
    logic [31:0] sig_q [$];
    logic [31:0] coef_q [$];
    logic [31:0] mon_w;

    int   checks = 0;
    int   failures = 0;
    int   sig_seen = 0;
    int   coef_seen = 0;
    int   done_seen = 0;
    logic full_at_edge = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // full_mul_i as seen by the DUT at the edge that set the strobes
    always @(posedge clk_i) full_at_edge <= bus.full_mul_i;

    always @(negedge clk_i) begin
        if (bus.signal_wr_o) begin
            if (sig_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sig_extra actual=%0h required=none",
                         bus.signal_fifo);
            end else begin
                mon_w = sig_q.pop_front();
                check("sig_word", {32'd0, bus.signal_fifo}, {32'd0, mon_w});
            end
            sig_seen++;
        end
        if (bus.coeff_wr_o) begin
            if (coef_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL coef_extra actual=%0h required=none",
                         bus.coeff_fifo);
            end else begin
                mon_w = coef_q.pop_front();
                check("coef_word", {32'd0, bus.coeff_fifo}, {32'd0, mon_w});
            end
            coef_seen++;
        end
        if (bus.signal_wr_o || bus.coeff_wr_o) begin
            check("strobe_after_full", {63'd0, full_at_edge}, 64'd0);
        end
        if (done_o) done_seen++;
    end

    task automatic check_idle_outputs(string tag);
        check({tag, "_sig_data"}, {32'd0, bus.signal_fifo}, 64'd0);
        check({tag, "_coef_data"}, {32'd0, bus.coeff_fifo}, 64'd0);
        check({tag, "_ctl"},
              {58'd0, bus.signal_wr_o, bus.coeff_wr_o, bus.samp_ready_o,
               busy_o, done_o, 1'b0}, 64'd0);
    endtask

    task automatic run_stream(input vec_t v);
        int   k;
        int   stall_cnt;
        bit   stall_done;
        bit   acc;
        bit   fin;
        sig_q.delete();
        coef_q.delete();
        sig_seen  = 0;
        coef_seen = 0;
        done_seen = 0;
        for (int i = 0; i < v.ns; i++) sig_q.push_back(samp[i]);
        sig_q.push_back(SENT);
        for (int i = v.nt; i >= 0; i--) coef_q.push_back(model[i]);
        coef_q.push_back(SENT);

        n_terms_i = v.nt[AL-1:0];
        n_samp_i  = v.ns[AL:0];
        start_i   = 1'b1;
        tick();
        start_i    = 1'b0;
        k          = 0;
        fin        = 1'b0;
        stall_done = 1'b0;
        stall_cnt  = 0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            bus.samp_valid_i = (v.vmode == 0) ? 1'b1 : (cyc % 2 == 0);
            bus.samp_data_i  = samp[k];
            if (v.fmode == 1) begin
                if (!stall_done && coef_seen == v.nt - v.stall_idx - 1) begin
                    stall_cnt  = 4;
                    stall_done = 1'b1;
                end
                bus.full_mul_i = (stall_cnt > 0);
                if (stall_cnt > 0) stall_cnt--;
            end else if (v.fmode == 2) begin
                bus.full_mul_i = ($urandom % 3 == 0);
            end else begin
                bus.full_mul_i = 1'b0;
            end
            if (v.poke != 0 && cyc == 3) begin
                start_i   = 1'b1;
                n_terms_i = '0;
                n_samp_i  = '0;
                cw_en_i   = 1'b1;
                cw_addr_i = v.nt[AL-1:0];
                cw_data_i = 32'hDEAD_BEEF;
            end else begin
                start_i = 1'b0;
                cw_en_i = 1'b0;
            end
            @(negedge clk_i);
            acc = bus.samp_valid_i && bus.samp_ready_o;
            if (done_seen > 0) fin = 1'b1;
            tick();
            if (acc) k++;
        end
        bus.samp_valid_i = 1'b0;
        bus.full_mul_i   = 1'b0;
        start_i          = 1'b0;
        cw_en_i          = 1'b0;
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout actual=no_done required=done");
        end
        tick();
        tick();
        @(negedge clk_i);
        check("busy_after", {63'd0, busy_o}, 64'd0);
        check("done_pulses", 64'(done_seen), 64'd1);
        check("sig_count", 64'(sig_seen), 64'(v.exp_sig));
        check("coef_count", 64'(coef_seen), 64'(v.exp_coef));
        check("samples_accepted", 64'(k), 64'(v.ns));
        check("queues_drained", 64'(sig_q.size() + coef_q.size()), 64'd0);
        tick();
    endtask

    task automatic reset_mid_stream();
        int k;
        bit acc;
        sig_q.delete();
        coef_q.delete();
        sig_seen = 0;
        sig_q.push_back(samp[0]);
        sig_q.push_back(samp[1]);
        n_terms_i = 5'd5;
        n_samp_i  = 6'd10;
        start_i   = 1'b1;
        tick();
        start_i          = 1'b0;
        bus.samp_valid_i = 1'b1;
        k                = 0;
        bus.samp_data_i  = samp[0];
        for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
            @(negedge clk_i);
            acc = bus.samp_valid_i && bus.samp_ready_o;
            tick();
            if (acc) k++;
            bus.samp_data_i = samp[k];
        end
        if (k != 2) begin
            checks++;
            failures++;
            $display("FAIL rst_seq_timeout actual=%0d required=2", k);
        end
        bus.samp_valid_i = 1'b0;
        rst_i            = 1'b1;
        start_i          = 1'b1;
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("mid_rst");
        tick();
        tick();
        @(negedge clk_i);
        check("start_with_rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_sig_count", 64'(sig_seen), 64'd2);
        sig_q.delete();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h3E00_0000 + i * 32'h0013_5791;
        for (int i = 0; i < 40; i++) samp[i] = $urandom;

        vecs[0] = '{nt: 30, ns: 30, vmode: 0, fmode: 0, stall_idx: 0,
                    poke: 0, exp_sig: 31, exp_coef: 32};
        vecs[1] = '{nt: 0, ns: 0, vmode: 0, fmode: 0, stall_idx: 0,
                    poke: 0, exp_sig: 1, exp_coef: 2};
        vecs[2] = '{nt: 30, ns: 8, vmode: 0, fmode: 1, stall_idx: 12,
                    poke: 0, exp_sig: 9, exp_coef: 32};
        vecs[3] = '{nt: 3, ns: 4, vmode: 1, fmode: 0, stall_idx: 0,
                    poke: 0, exp_sig: 5, exp_coef: 5};
        vecs[4] = '{nt: 7, ns: 12, vmode: 1, fmode: 2, stall_idx: 0,
                    poke: 1, exp_sig: 13, exp_coef: 9};
        vecs[5] = '{nt: 31, ns: 32, vmode: 0, fmode: 2, stall_idx: 0,
                    poke: 0, exp_sig: 33, exp_coef: 33};
        vecs[6] = '{nt: 5, ns: 3, vmode: 0, fmode: 0, stall_idx: 0,
                    poke: 0, exp_sig: 4, exp_coef: 7};

        rst_i            = 1'b1;
        cw_en_i          = 1'b0;
        cw_addr_i        = '0;
        cw_data_i        = '0;
        start_i          = 1'b0;
        n_terms_i        = '0;
        n_samp_i         = '0;
        bus.samp_valid_i = 1'b0;
        bus.samp_data_i  = '0;
        bus.full_mul_i   = 1'b0;
        tick();
        tick();
        @(negedge clk_i);
        check_idle_outputs("reset");
        tick();
        rst_i = 1'b0;

        for (int i = 0; i < 32; i++) begin
            cw_en_i   = 1'b1;
            cw_addr_i = i[AL-1:0];
            cw_data_i = model[i];
            tick();
        end
        cw_en_i = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_stream(vecs[i]);
        reset_mid_stream();
        run_stream(vecs[6]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
